wf_zoom_ctrl: RTL and testbench
===============================

Name: wf_zoom_ctrl

Overview:
- Parametrised successor to the waveform display-limit controller.
- Holds the waveform viewport rectangle (start_x/end_x/start_y/end_y) fed to the waveform renderer.
- Supports N zoom-out levels with per-axis step sizes and saturation at the full-screen bounds.
- Detects button edges internally and drives registered limits, a zoom-level indicator and a settled flag.

Parameters:
- COORD_W, 10, coordinate width in bits.
- LEVELS, 4, number of expansion levels above default (>=1).
- LVL_W, 3, width of zoom_level; must satisfy 2^LVL_W > LEVELS.
- DEF_START_X, 138, default-view left edge.
- DEF_END_X, 838, default-view right edge.
- DEF_START_Y, 62, default-view top edge.
- DEF_END_Y, 482, default-view bottom edge.
- MAX_START_X, 88, full-screen left edge.
- MAX_END_X, 888, full-screen right edge.
- MAX_START_Y, 32, full-screen top edge.
- MAX_END_Y, 512, full-screen bottom edge.
- STEP_X, 10, per-level x expansion per side.
- STEP_Y, 6, per-level y expansion per side.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_full  in  1  level-sensitive button: full-screen / home
- btn_in  in  1  level-sensitive button: expand one level
- btn_out  in  1  level-sensitive button: shrink one level
- start_x  out  COORD_W  registered viewport left
- end_x  out  COORD_W  registered viewport right
- start_y  out  COORD_W  registered viewport top
- end_y  out  COORD_W  registered viewport bottom
- zoom_level  out  LVL_W  current level; 0 = default
- full_mode  out  1  1 while in FULL state
- settled  out  1  1 when outputs equal the current target

Behaviour:
- Reset (rst low, async):
  - state DEFAULT, zoom_level 0, full_mode 0, settled 1.
  - Outputs = DEF_* values.
  - Button history registers cleared to 0.
- Edge detection:
  - Each button registered every clock.
  - Event = btn & ~btn_prev.
  - A held button produces exactly one event.
- Priority: when several events occur in the same cycle, only the highest-priority one acts: full > in > out.
- FSM (updates on the clock edge at which the event is seen):
  - DEFAULT:
    - full -> FULL.
    - in -> ZOOM, level 1.
    - out -> ignored.
  - ZOOM (level 1..LEVELS):
    - in -> level+1; at level LEVELS, in -> FULL.
    - out -> level-1; out from level 1 -> DEFAULT.
    - full -> DEFAULT (home), level 0.
  - FULL:
    - full -> DEFAULT.
    - out -> ZOOM, level LEVELS.
    - in -> ignored.
  - zoom_level reads LEVELS while in FULL; full_mode = (state==FULL).
- Target computation (combinational from state/level):
  - Use COORD_W+LVL_W+4 bits, no wrap.
  - tgt_start_x = max(DEF_START_X - level*STEP_X, MAX_START_X).
  - tgt_end_x = min(DEF_END_X + level*STEP_X, MAX_END_X).
  - Y axis uses the same rules with STEP_Y and the Y bounds.
  - Subtraction must not underflow below 0 before the clamp.
  - FULL: targets = MAX_* exactly.
- Latency (macro off):
  - Button rises before edge k -> state/level change at edge k -> limit outputs change at edge k+1.
  - settled held at 1.
- Outputs always satisfy start < end on both axes, given legal parameters.

Optional Feature:
- Macro: WF_ZOOM_ANIM_EN.
- Defined:
  - Each limit register slews toward its target by at most STEP_X (x) or STEP_Y (y) per clock, landing exactly on the target (no overshoot).
  - settled = all four outputs equal their targets; it drops in the cycle after a target change.
  - Events during slewing are accepted and retarget immediately.
  - Reset mid-slew snaps to DEF_* asynchronously.
- Undefined: outputs load their targets directly (one-cycle latency as above); settled tied to 1.

Test Plan:
- Reset with buttons held high, then release rst -> outputs 138/838/62/482, level 0; no event until a button goes low then high again.
- btn_in pulsed 3 times (LEVELS=4) -> level 3; outputs 108/868/44/500, each one cycle after the FSM update.
- From level 4, pulse btn_in -> FULL, outputs 88/888/32/512, full_mode 1; then btn_out -> level 4, outputs 98/878/38/506.
- LEVELS=8, pulse btn_in 6 times -> start_x clamped at 88 (not 78), start_y clamped at 32 (not 26), end_x 888, end_y 518 clamped to 512.
- btn_full, btn_in and btn_out rising in the same cycle from level 2 -> DEFAULT, outputs 138/838/62/482; btn_out alone in DEFAULT -> no change.
- WF_ZOOM_ANIM_EN, DEFAULT -> btn_full -> start_x steps 138,128,…,88 over 5 cycles; start_y 62,56,…,32; settled 0 until the final value, then 1.

Source files
------------

// File: rtl/wf_zoom_ctrl_if.sv
// Button inputs and viewport outputs of the waveform zoom controller.
// The master side drives the buttons; the slave side (the controller) drives the limits and status.
interface wf_zoom_ctrl_if #(
    parameter int COORD_W = 10,
    parameter int LVL_W   = 3
);
    logic               btn_full;
    logic               btn_in;
    logic               btn_out;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] end_x;
    logic [COORD_W-1:0] start_y;
    logic [COORD_W-1:0] end_y;
    logic [LVL_W-1:0]   zoom_level;
    logic               full_mode;
    logic               settled;

    modport master (
        output btn_full, btn_in, btn_out,
        input  start_x, end_x, start_y, end_y, zoom_level, full_mode, settled
    );

    modport slave (
        input  btn_full, btn_in, btn_out,
        output start_x, end_x, start_y, end_y, zoom_level, full_mode, settled
    );
endinterface

// File: rtl/wf_zoom_ctrl.sv
// Waveform viewport controller: N zoom-out levels with clamping; WF_ZOOM_ANIM_EN slews limits toward targets.
// Latency: button edge seen at edge k -> state at k -> limits at k+1 (or slewing from k+1); no backpressure.
module wf_zoom_ctrl #(
    parameter int COORD_W     = 10,
    parameter int LEVELS      = 4,
    parameter int LVL_W       = 3,
    parameter int DEF_START_X = 138,
    parameter int DEF_END_X   = 838,
    parameter int DEF_START_Y = 62,
    parameter int DEF_END_Y   = 482,
    parameter int MAX_START_X = 88,
    parameter int MAX_END_X   = 888,
    parameter int MAX_START_Y = 32,
    parameter int MAX_END_Y   = 512,
    parameter int STEP_X      = 10,
    parameter int STEP_Y      = 6
) (
    input  logic          clk,
    input  logic          rst,
    wf_zoom_ctrl_if.slave zif
);

    localparam int W = COORD_W + LVL_W + 4;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_ZOOM    = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             state_q;
    logic [LVL_W-1:0]   level_q;
    logic               full_mode_q;
    logic [2:0]         btn_prev_q;
    logic               armed_q;
    logic [2:0]         btn_now;
    logic [2:0]         btn_ev;
    logic               ev_full;
    logic               ev_in;
    logic               ev_out;

    logic [COORD_W-1:0] tgt_sx, tgt_ex, tgt_sy, tgt_ey;
    logic [COORD_W-1:0] sx_d, ex_d, sy_d, ey_d;
    logic [COORD_W-1:0] sx_q, ex_q, sy_q, ey_q;

    // Buttons already high when reset releases are absorbed into the history on the first clock.
    assign btn_now = {zif.btn_full, zif.btn_in, zif.btn_out};
    assign btn_ev  = armed_q ? (btn_now & ~btn_prev_q) : 3'b000;
    assign ev_full = btn_ev[2];
    assign ev_in   = btn_ev[1] & ~btn_ev[2];
    assign ev_out  = btn_ev[0] & ~btn_ev[2] & ~btn_ev[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DEFAULT;
            level_q     <= '0;
            full_mode_q <= 1'b0;
            btn_prev_q  <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_now;
            armed_q    <= 1'b1;
            case (state_q)
                ST_DEFAULT: begin
                    if (ev_full) begin
                        state_q     <= ST_FULL;
                        level_q     <= LVL_MAX;
                        full_mode_q <= 1'b1;
                    end else if (ev_in) begin
                        state_q <= ST_ZOOM;
                        level_q <= LVL_ONE;
                    end
                end
                ST_ZOOM: begin
                    if (ev_full) begin
                        state_q <= ST_DEFAULT;
                        level_q <= '0;
                    end else if (ev_in) begin
                        if (level_q == LVL_MAX) begin
                            state_q     <= ST_FULL;
                            full_mode_q <= 1'b1;
                        end else begin
                            level_q <= level_q + LVL_ONE;
                        end
                    end else if (ev_out) begin
                        if (level_q == LVL_ONE) begin
                            state_q <= ST_DEFAULT;
                            level_q <= '0;
                        end else begin
                            level_q <= level_q - LVL_ONE;
                        end
                    end
                end
                ST_FULL: begin
                    if (ev_full) begin
                        state_q     <= ST_DEFAULT;
                        level_q     <= '0;
                        full_mode_q <= 1'b0;
                    end else if (ev_out) begin
                        state_q     <= ST_ZOOM;
                        level_q     <= LVL_MAX;
                        full_mode_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_DEFAULT;
                    level_q     <= '0;
                    full_mode_q <= 1'b0;
                end
            endcase
        end
    end

    // Lower edge: compare the offset against the available headroom so the subtraction never wraps.
    function automatic logic [COORD_W-1:0] lo_edge(input int def_v, input int max_v,
                                                   input int step, input logic [LVL_W-1:0] lvl);
        logic [W-1:0] off;
        off = W'(lvl) * W'(step);
        if (off >= W'(def_v - max_v)) return COORD_W'(max_v);
        return COORD_W'(W'(def_v) - off);
    endfunction

    function automatic logic [COORD_W-1:0] hi_edge(input int def_v, input int max_v,
                                                   input int step, input logic [LVL_W-1:0] lvl);
        logic [W-1:0] sum;
        sum = W'(def_v) + W'(lvl) * W'(step);
        if (sum >= W'(max_v)) return COORD_W'(max_v);
        return COORD_W'(sum);
    endfunction

    always_comb begin
        tgt_sx = lo_edge(DEF_START_X, MAX_START_X, STEP_X, level_q);
        tgt_ex = hi_edge(DEF_END_X,   MAX_END_X,   STEP_X, level_q);
        tgt_sy = lo_edge(DEF_START_Y, MAX_START_Y, STEP_Y, level_q);
        tgt_ey = hi_edge(DEF_END_Y,   MAX_END_Y,   STEP_Y, level_q);
        if (state_q == ST_FULL) begin
            tgt_sx = COORD_W'(MAX_START_X);
            tgt_ex = COORD_W'(MAX_END_X);
            tgt_sy = COORD_W'(MAX_START_Y);
            tgt_ey = COORD_W'(MAX_END_Y);
        end
    end

`ifdef WF_ZOOM_ANIM_EN
    function automatic logic [COORD_W-1:0] slew(input logic [COORD_W-1:0] cur,
                                                input logic [COORD_W-1:0] tgt, input int step);
        logic [COORD_W-1:0] stp;
        stp = COORD_W'(step);
        if (cur < tgt) return ((tgt - cur) > stp) ? (cur + stp) : tgt;
        if (cur > tgt) return ((cur - tgt) > stp) ? (cur - stp) : tgt;
        return cur;
    endfunction

    always_comb begin
        sx_d = slew(sx_q, tgt_sx, STEP_X);
        ex_d = slew(ex_q, tgt_ex, STEP_X);
        sy_d = slew(sy_q, tgt_sy, STEP_Y);
        ey_d = slew(ey_q, tgt_ey, STEP_Y);
    end

    assign zif.settled = (sx_q == tgt_sx) && (ex_q == tgt_ex) &&
                         (sy_q == tgt_sy) && (ey_q == tgt_ey);
`else
    always_comb begin
        sx_d = tgt_sx;
        ex_d = tgt_ex;
        sy_d = tgt_sy;
        ey_d = tgt_ey;
    end

    assign zif.settled = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q <= COORD_W'(DEF_START_X);
            ex_q <= COORD_W'(DEF_END_X);
            sy_q <= COORD_W'(DEF_START_Y);
            ey_q <= COORD_W'(DEF_END_Y);
        end else begin
            sx_q <= sx_d;
            ex_q <= ex_d;
            sy_q <= sy_d;
            ey_q <= ey_d;
        end
    end

    assign zif.start_x    = sx_q;
    assign zif.end_x      = ex_q;
    assign zif.start_y    = sy_q;
    assign zif.end_y      = ey_q;
    assign zif.zoom_level = level_q;
    assign zif.full_mode  = full_mode_q;

endmodule

// File: tb/tb_wf_zoom_ctrl.sv
// Self-checking bench for wf_zoom_ctrl: vector table, corner sequences and a randomized reference-model run.
module tb_wf_zoom_ctrl;

    localparam int L = 4;
`ifdef WF_ZOOM_ANIM_EN
    localparam int SETTLE = 7;
`else
    localparam int SETTLE = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wf_zoom_ctrl_if #(.COORD_W(10), .LVL_W(3)) zif4 ();
    wf_zoom_ctrl_if #(.COORD_W(10), .LVL_W(4)) zif8 ();

    wf_zoom_ctrl u_dut4 (.clk(clk), .rst(rst), .zif(zif4));
    wf_zoom_ctrl #(.LEVELS(8), .LVL_W(4)) u_dut8 (.clk(clk), .rst(rst), .zif(zif8));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: abstract zoom position, independent of any encoding.
    int       m_level;
    bit       m_full;
    bit       m_first;
    bit [2:0] m_prev;
    int       e_sx, e_ex, e_sy, e_ey;

    typedef struct {
        bit f, i, o;
        int lvl, sx, ex, sy, ey;
        bit fm;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int lo_ref(input int d, input int m, input int s, input int l, input bit f);
        int v;
        if (f) return m;
        v = d - l * s;
        return (v > m) ? v : m;
    endfunction

    function automatic int hi_ref(input int d, input int m, input int s, input int l, input bit f);
        int v;
        if (f) return m;
        v = d + l * s;
        return (v < m) ? v : m;
    endfunction

    task automatic tick();
        bit [2:0] b, ev;
        if (!rst) begin
            m_full = 0; m_level = 0; m_prev = 3'b000; m_first = 1;
            e_sx = 138; e_ex = 838; e_sy = 62; e_ey = 482;
        end else begin
            e_sx = lo_ref(138, 88, 10, m_level, m_full);
            e_ex = hi_ref(838, 888, 10, m_level, m_full);
            e_sy = lo_ref(62, 32, 6, m_level, m_full);
            e_ey = hi_ref(482, 512, 6, m_level, m_full);
            b = {zif4.btn_full, zif4.btn_in, zif4.btn_out};
            ev = m_first ? 3'b000 : (b & ~m_prev);
            m_prev = b;
            m_first = 0;
            if (ev[2]) begin
                if (m_full || m_level != 0) begin m_full = 0; m_level = 0; end
                else begin m_full = 1; m_level = L; end
            end else if (ev[1]) begin
                if (!m_full) begin
                    if (m_level == L) m_full = 1;
                    else m_level++;
                end
            end else if (ev[0]) begin
                if (m_full) begin m_full = 0; m_level = L; end
                else if (m_level > 0) m_level--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input bit f, input bit i, input bit o);
        zif4.btn_full = f; zif4.btn_in = i; zif4.btn_out = o;
    endtask

    task automatic check_view4(input string tag, input int sx, input int ex, input int sy, input int ey);
        chk({tag, "_sx"}, int'(zif4.start_x), sx);
        chk({tag, "_ex"}, int'(zif4.end_x), ex);
        chk({tag, "_sy"}, int'(zif4.start_y), sy);
        chk({tag, "_ey"}, int'(zif4.end_y), ey);
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1, 128, 848, 56, 488, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 2, 118, 858, 50, 494, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 3, 108, 868, 44, 500, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 4,  98, 878, 38, 506, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 4,  88, 888, 32, 512, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 4,  88, 888, 32, 512, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 4,  98, 878, 38, 506, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 3, 108, 868, 44, 500, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 0, 138, 838, 62, 482, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 0, 138, 838, 62, 482, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 4,  88, 888, 32, 512, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b0, 0, 138, 838, 62, 482, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1, 128, 848, 56, 488, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 2, 118, 858, 50, 494, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b1, 0, 138, 838, 62, 482, 1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b1, 0, 138, 838, 62, 482, 1'b0};

        rst = 1'b0;
        set4(1, 1, 1);
        zif8.btn_full = 1'b0; zif8.btn_in = 1'b0; zif8.btn_out = 1'b0;

        // Reset with every button held high, then release.
        repeat (3) tick();
        check_view4("rst", 138, 838, 62, 482);
        chk("rst_lvl", int'(zif4.zoom_level), 0);
        chk("rst_full", int'(zif4.full_mode), 0);
        chk("rst_settled", int'(zif4.settled), 1);
        rst = 1'b1;
        repeat (3) tick();
        chk("held_lvl", int'(zif4.zoom_level), 0);
        check_view4("held", 138, 838, 62, 482);
        chk("held_full", int'(zif4.full_mode), 0);
        set4(0, 0, 0);
        tick();
        set4(0, 1, 0);
        tick();
        chk("rearm_lvl", int'(zif4.zoom_level), 1);
        set4(0, 0, 0);
        tick();
        chk("rearm_sx", int'(zif4.start_x), 128);

        // One-cycle lag between state and limits; a held button steps only once.
        set4(0, 1, 0);
        tick();
        chk("lat_lvl", int'(zif4.zoom_level), 2);
        chk("lat_sx_old", int'(zif4.start_x), 128);
        tick();
        chk("lat_sx_new", int'(zif4.start_x), 118);
        repeat (3) tick();
        chk("hold_lvl", int'(zif4.zoom_level), 2);
        set4(0, 0, 0);
        tick();

        // Asynchronous reset takes effect without a clock edge.
        rst = 1'b0;
        #1;
        check_view4("arst", 138, 838, 62, 482);
        chk("arst_lvl", int'(zif4.zoom_level), 0);
        tick();
        rst = 1'b1;
        tick();

        // Eight-level instance clamps at the full-screen bounds.
        for (int k = 0; k < 6; k++) begin
            zif8.btn_in = 1'b1;
            tick();
            zif8.btn_in = 1'b0;
            repeat (SETTLE) tick();
        end
        chk("l8_lvl", int'(zif8.zoom_level), 6);
        chk("l8_sx", int'(zif8.start_x), 88);
        chk("l8_ex", int'(zif8.end_x), 888);
        chk("l8_sy", int'(zif8.start_y), 32);
        chk("l8_ey", int'(zif8.end_y), 512);
        chk("l8_full", int'(zif8.full_mode), 0);

`ifdef WF_ZOOM_ANIM_EN
        set4(1, 0, 0);
        tick();
        chk("anim_sx0", int'(zif4.start_x), 138);
        chk("anim_settled0", int'(zif4.settled), 0);
        set4(0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("anim_sx", int'(zif4.start_x), 138 - 10 * k);
            chk("anim_sy", int'(zif4.start_y), 62 - 6 * k);
            chk("anim_settled", int'(zif4.settled), (k == 5) ? 1 : 0);
        end
        set4(1, 0, 0);
        tick();
        set4(0, 0, 0);
        repeat (SETTLE) tick();
`endif

        for (int r = 0; r < 16; r++) begin
            set4(vt[r].f, vt[r].i, vt[r].o);
            tick();
            set4(0, 0, 0);
            repeat (SETTLE) tick();
            check_view4($sformatf("vec%0d", r), vt[r].sx, vt[r].ex, vt[r].sy, vt[r].ey);
            chk($sformatf("vec%0d_lvl", r), int'(zif4.zoom_level), vt[r].lvl);
            chk($sformatf("vec%0d_full", r), int'(zif4.full_mode), int'(vt[r].fm));
            chk($sformatf("vec%0d_settled", r), int'(zif4.settled), 1);
        end

`ifndef WF_ZOOM_ANIM_EN
        for (int c = 0; c < 400; c++) begin
            set4($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
            tick();
            check_view4("rnd", e_sx, e_ex, e_sy, e_ey);
            chk("rnd_lvl", int'(zif4.zoom_level), m_level);
            chk("rnd_full", int'(zif4.full_mode), int'(m_full));
            chk("rnd_order", int'(zif4.start_x < zif4.end_x && zif4.start_y < zif4.end_y), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
